// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the operand-fetch stage: opcode constants,
// instruction field layout, default widths and the write-class decode.
// Imported by the top and by the scoreboard.
package operand_fetch_stage_pkg;

  localparam int LENGTH_DEF         = 16;
  localparam int REG_FILE_DEPTH_DEF = 8;
  localparam int ADDR_W_DEF         = 3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_BR  = 4'hC;

  // Field bit positions inside the 16-bit instruction word
  localparam int OPC_MSB = 15, OPC_LSB = 12;
  localparam int RD_MSB  = 11, RD_LSB  = 9;
  localparam int RS1_MSB = 8,  RS1_LSB = 6;
  localparam int RS2_MSB = 5,  RS2_LSB = 3;
  localparam int FN_MSB  = 2,  FN_LSB  = 0;

  // Packed view of the instruction; field order matches the positions above
  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] funct;
  } instr_t;

  // Everything except NOP, store and branch produces a register result
  function automatic logic writesRd(input logic [3:0] opc);
    return !(opc == OP_NOP || opc == OP_ST || opc == OP_BR);
  endfunction

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// Purpose: one pending bit per architectural register, set on issue, cleared on writeback or flush.
// Latency: updates visible one cycle after the set/clear strobe; lookups are combinational.
// Backpressure: none; the owner gates the set strobe with its own issue condition.
module of_scoreboard
  import operand_fetch_stage_pkg::*;
#(
  parameter int DEPTH  = REG_FILE_DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              setEn,
  input  logic [ADDR_W-1:0] setIdx,
  input  logic              wbClrEn,
  input  logic [ADDR_W-1:0] wbClrIdx,
  input  logic              flushClrEn,
  input  logic [ADDR_W-1:0] flushClrIdx,
  input  logic [ADDR_W-1:0] rs1Idx,
  input  logic [ADDR_W-1:0] rs2Idx,
  input  logic [ADDR_W-1:0] rdIdx,
  output logic              rs1Pend,
  output logic              rs2Pend,
  output logic              rdPend
);

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pendingNext;

  // Clears first, then set, so a new writer of a register being retired keeps it pending
  always_comb begin
    pendingNext = pending;
    if (wbClrEn)    pendingNext[wbClrIdx]    = 1'b0;
    if (flushClrEn) pendingNext[flushClrIdx] = 1'b0;
    if (setEn)      pendingNext[setIdx]      = 1'b1;
  end

  // Pending-bit register, dropped entirely on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= pendingNext;
  end

  assign rs1Pend = pending[rs1Idx];
  assign rs2Pend = pending[rs2Idx];
  assign rdPend  = pending[rdIdx];

endmodule

// File: rtl/operand_fetch_stage.sv
// Purpose: decode, register-file addressing, RAW/WAW hazard stall, writeback forwarding, operand register.
// Latency: instruction issued in cycle N appears on ex_* in cycle N+1; back-to-back issue supported.
// Backpressure: if_ready drops on hazard, flush, or a held bundle that execute has not consumed.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int LENGTH         = LENGTH_DEF,
  parameter int REG_FILE_DEPTH = REG_FILE_DEPTH_DEF,
  parameter int ADDR_W         = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_valid,
  input  logic [LENGTH-1:0] if_instr,
  output logic              if_ready,
  output logic [ADDR_W-1:0] dataAddr0,
  output logic [ADDR_W-1:0] dataAddr1,
  input  logic [LENGTH-1:0] readData0,
  input  logic [LENGTH-1:0] readData1,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [LENGTH-1:0] wb_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [3:0]        ex_opcode,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [2:0]        ex_funct,
  output logic              ex_wr,
  output logic [LENGTH-1:0] ex_op0,
  output logic [LENGTH-1:0] ex_op1
);

  instr_t            ins;
  logic              isNop;
  logic              wrNeeded;
  logic              wbHit0;
  logic              wbHit1;
  logic              wbHitRd;
  logic              rs1Pend;
  logic              rs2Pend;
  logic              rdPend;
  logic              hazard;
  logic              issue;
  logic [LENGTH-1:0] op0;
  logic [LENGTH-1:0] op1;

  assign ins       = if_instr;
  assign dataAddr0 = ins.rs1;
  assign dataAddr1 = ins.rs2;

  assign isNop    = (ins.opcode == OP_NOP);
  assign wrNeeded = writesRd(ins.opcode);

  // The register file commits on the same edge we sample, so writeback data must bypass it
  assign wbHit0  = wb_valid && (wb_rd == ins.rs1);
  assign wbHit1  = wb_valid && (wb_rd == ins.rs2);
  assign wbHitRd = wb_valid && (wb_rd == ins.rd);

  // NOP reads nothing; its operand slots are zeroed so the bundle is deterministic
  assign op0 = isNop ? '0 : (wbHit0 ? wb_data : readData0);
  assign op1 = isNop ? '0 : (wbHit1 ? wb_data : readData1);

  // A pending register being written back this cycle is already safe to use
  assign hazard = (!isNop && ((rs1Pend && !wbHit0) || (rs2Pend && !wbHit1)))
                || (wrNeeded && rdPend && !wbHitRd);

  assign if_ready = !flush && !hazard && (!ex_valid || ex_ready);
  assign issue    = if_valid && if_ready;

  of_scoreboard #(
    .DEPTH  (REG_FILE_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .setEn       (issue && wrNeeded),
    .setIdx      (ins.rd),
    .wbClrEn     (wb_valid),
    .wbClrIdx    (wb_rd),
    .flushClrEn  (flush && ex_valid && ex_wr),
    .flushClrIdx (ex_rd),
    .rs1Idx      (ins.rs1),
    .rs2Idx      (ins.rs2),
    .rdIdx       (ins.rd),
    .rs1Pend     (rs1Pend),
    .rs2Pend     (rs2Pend),
    .rdPend      (rdPend)
  );

  // Output bundle: load on issue, kill on flush, retire when consumed, otherwise hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid  <= 1'b0;
      ex_opcode <= '0;
      ex_rd     <= '0;
      ex_funct  <= '0;
      ex_wr     <= 1'b0;
      ex_op0    <= '0;
      ex_op1    <= '0;
    end else if (issue) begin
      ex_valid  <= 1'b1;
      ex_opcode <= ins.opcode;
      ex_rd     <= ins.rd;
      ex_funct  <= ins.funct;
      ex_wr     <= wrNeeded;
      ex_op0    <= op0;
      ex_op1    <= op1;
    end else if (flush || ex_ready) begin
      ex_valid  <= 1'b0;
    end
  end

endmodule
